// File: rtl/axis_arbiter_rr_32_pkg.sv
// Shared types and constants for the packet-level AXI4-Stream round-robin arbiter.
package axis_arbiter_rr_32_pkg;

    localparam int AXIS_DATA_BITS = 32;
    localparam int AXIS_KEEP_BITS = AXIS_DATA_BITS / 8;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE   = 1'b0;
    localparam arb_state_t LOCKED = 1'b1;

endpackage

// File: rtl/axis_arbiter_rr_32_if.sv
// AXI4-Stream bundle; N lanes wide on the source side, one lane plus tid on the sink side.
interface axis_arbiter_rr_32_if
    import axis_arbiter_rr_32_pkg::*;
#(
    parameter int N       = 1,
    parameter int ID_BITS = 1
) ();

    logic [N-1:0]                tvalid;
    logic [N-1:0]                tready;
    logic [N*AXIS_DATA_BITS-1:0] tdata;
    logic [N*AXIS_KEEP_BITS-1:0] tkeep;
    logic [N-1:0]                tlast;
    logic [ID_BITS-1:0]          tid;

    modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);

endinterface

// File: rtl/axis_arbiter_rr_32_rr_pick_next.sv
// Rotate-priority encoder: first set bit of req strictly after ptr, wrapping modulo N.
module axis_arbiter_rr_32_rr_pick_next #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest request overwrites.
    always_comb begin
        idx   = '0;
        valid = |req;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
            if (req[cand[W-1:0]]) idx = cand[W-1:0];
        end
    end

endmodule

// File: rtl/axis_arbiter_rr_32.sv
// Packet-level round-robin arbiter: locks onto one source until its tlast beat is accepted.
module axis_arbiter_rr_32
    import axis_arbiter_rr_32_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int SRC_BITS = $clog2(N_SRC),
    parameter int CNT_BITS = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_arbiter_rr_32_if.slave  s_axis,
    axis_arbiter_rr_32_if.master m_axis,
    input  logic [N_SRC-1:0]     arb_en,
    output logic [CNT_BITS-1:0]  pkt_cnt,
    output logic                 busy
);

    localparam logic [SRC_BITS-1:0] PTR_RST = SRC_BITS'(N_SRC - 1);

    arb_state_t          state;
    logic [SRC_BITS-1:0] grant;
    logic [SRC_BITS-1:0] rr_ptr;
    logic [SRC_BITS-1:0] nxt_idx;
    logic                nxt_vld;
    logic [N_SRC-1:0]    req;
    logic                locked;
    logic                pkt_done;

    assign req    = s_axis.tvalid & arb_en;
    assign locked = (state == LOCKED);
    assign busy   = locked;

    axis_arbiter_rr_32_rr_pick_next #(
        .N (N_SRC),
        .W (SRC_BITS)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (nxt_idx),
        .valid (nxt_vld)
    );

    // Payload always follows grant so the master side never carries X while idle.
    always_comb begin
        m_axis.tvalid        = locked & s_axis.tvalid[grant];
        m_axis.tdata         = s_axis.tdata[grant*AXIS_DATA_BITS +: AXIS_DATA_BITS];
        m_axis.tkeep         = s_axis.tkeep[grant*AXIS_KEEP_BITS +: AXIS_KEEP_BITS];
        m_axis.tlast         = s_axis.tlast[grant];
        m_axis.tid           = grant;
        s_axis.tready        = '0;
        s_axis.tready[grant] = locked & m_axis.tready[0];
    end

    assign pkt_done = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= PTR_RST;
            pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (nxt_vld) begin
                        state <= LOCKED;
                        grant <= nxt_idx;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        state   <= IDLE;
                        rr_ptr  <= grant;
                        pkt_cnt <= pkt_cnt + CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_arbiter_rr_32.md
Name: axis_arbiter_rr_32

Overview:
- Packet-level round-robin arbiter that shares one 32-bit AXI4-Stream register slice between N_SRC requesters.
- Sits in the static region in front of axis_reg_static_32. Once a source is granted, the lock is held until that source's tlast beat is accepted, so packets never interleave.
- Provides a per-source enable mask, a source-ID sideband, and a packet counter for the host status registers.

Parameters:
- N_SRC, 4, number of requesting sources (2..16).
- SRC_BITS, $clog2(N_SRC), width of the source ID.
- CNT_BITS, 32, width of the packet counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset, synchronous to aclk, active-high.
- s_axis_tvalid  in  N_SRC  per-source valid.
- s_axis_tready  out  N_SRC  per-source ready.
- s_axis_tdata  in  N_SRC*32  per-source data; source i occupies bits [32i+31:32i].
- s_axis_tkeep  in  N_SRC*4  per-source keep.
- s_axis_tlast  in  N_SRC  per-source last.
- m_axis_tvalid  out  1  to the register slice.
- m_axis_tready  in  1  from the register slice.
- m_axis_tdata  out  32  muxed data.
- m_axis_tkeep  out  4  muxed keep.
- m_axis_tlast  out  1  muxed last.
- m_axis_tid  out  SRC_BITS  source of the current beat.
- arb_en  in  N_SRC  per-source enable mask, from a config register.
- pkt_cnt  out  CNT_BITS  count of packets completed (tlast beats accepted on the master side).
- busy  out  1  high while in the LOCKED state.

Behaviour:
- Single clock domain. Interface is AXI4-Stream; a beat transfers when tvalid && tready on the same edge.
- States:
  - IDLE: no grant. All s_axis_tready=0, m_axis_tvalid=0.
  - LOCKED: the source selected by grant (SRC_BITS register) is muxed straight through. Combinational path, zero latency:
    - m_axis_tvalid = s_axis_tvalid[grant]
    - s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0
    - tdata, tkeep, tlast are muxed from source grant; m_axis_tid = grant.
- Request vector: req = s_axis_tvalid & arb_en.
- IDLE -> LOCKED: when req != 0, grant <= the first set bit of req searching from rr_ptr+1 upward, wrapping modulo N_SRC. Arbitration is therefore one bubble cycle per packet; data moves from the cycle after the decision.
- LOCKED -> IDLE: on the cycle m_axis_tvalid && m_axis_tready && m_axis_tlast. On that edge: rr_ptr <= grant, and pkt_cnt increments.
- In LOCKED the grant is held even if:
  - the granted source deasserts tvalid mid-packet (bubbles pass through);
  - arb_en[grant] drops mid-packet. arb_en gates new grants only.
- If req == 0 in IDLE, the arbiter stays in IDLE and rr_ptr is unchanged.
- When only one source requests continuously, it is re-granted after each packet, with one idle cycle between packets.
- pkt_cnt wraps from 2^CNT_BITS-1 to 0 with no saturation and no flag.
- Reset values (areset=1 sampled on an aclk edge):
  - state=IDLE, grant=0, rr_ptr=N_SRC-1 (so source 0 has first priority), pkt_cnt=0.
  - All tready and m_axis_tvalid deassert combinationally from the next cycle's IDLE state.
- Reset mid-packet: the packet is truncated with no tlast emitted. Downstream recovery is the system's responsibility, and the reset must be applied to the register slice together with this block.
- Master outputs are don't-care while m_axis_tvalid=0, but tid, tdata, tkeep and tlast are driven from grant (no X propagation).
- No combinational path from m_axis_tready to m_axis_tvalid.

Decomposition:
- Shared package (lynxTypes): constant AXIS_DATA_BITS=32 and the arbiter state enum (IDLE, LOCKED).
- One sub-module: rr_pick_next (req, ptr -> idx, valid). A combinational rotate-priority encoder, reusable by other arbiters.
- The top level holds the FSM, the mux and the counter.

Test Plan:
1. Reset, then source 0 alone sends a 3-beat packet (data 0xA0..0xA2, last on beat 3) -> one idle cycle, then m_axis carries 3 beats with tid=0; pkt_cnt=1; busy falls the cycle after tlast.
2. All 4 sources hold continuous 2-beat packets with arb_en=0xF -> grant order 0,1,2,3,0,...; no interleaving within a packet; pkt_cnt=8 after 8 packets.
3. Source 2 is granted; m_axis_tready toggles 1,0,1,0 and s_axis_tvalid[2] drops for 2 cycles mid-packet -> no beat lost or duplicated; grant stays 2; other tready remain 0.
4. arb_en=0b1011 with all sources requesting -> source 2 is never granted. arb_en[0] cleared while source 0 is mid-packet -> source 0's packet completes, then grant moves to 1.
5. areset asserted on beat 2 of a 4-beat packet -> next cycle state=IDLE, busy=0, all tready=0, pkt_cnt=0; first grant after reset goes to the lowest requesting index.
6. pkt_cnt forced to 0xFFFFFFFF, then one packet completes -> pkt_cnt=0x00000000.
